rs_queue: RTL and testbench

RS_QUEUE -- requirements
Module: rs_queue

---
 rtl/rs_queue.sv | 191 +++++++++++++++++++
 tb/tb_rs_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_queue.sv
// Reservation-station queue: holds dispatched instructions until both operands
// are available (directly or via CDB broadcast), then issues one per cycle.
// Optional feature macro RS_AGE_ORDER_EN: when defined, a DEPTH x DEPTH age
// matrix makes issue pick the oldest ready entry; otherwise the lowest-index
// ready entry is issued and no age state exists.
module rs_queue #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        disp_valid,
  output logic                        disp_ready,
  input  logic [OP_W-1:0]             disp_op,
  input  logic [TAG_W-1:0]            disp_dest,
  input  logic                        disp_v1,
  input  logic                        disp_v2,
  input  logic [DATA_W-1:0]           disp_src1,
  input  logic [DATA_W-1:0]           disp_src2,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [OP_W-1:0]             issue_op,
  output logic [TAG_W-1:0]            issue_dest,
  output logic [DATA_W-1:0]           issue_opr1,
  output logic [DATA_W-1:0]           issue_opr2,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  // Entry storage; an operand field holds the waiting tag in its low bits
  // until the operand becomes valid.
  logic [DEPTH-1:0]  busy_reg;
  logic [OP_W-1:0]   op_reg   [DEPTH];
  logic [TAG_W-1:0]  dest_reg [DEPTH];
  logic [DEPTH-1:0]  v1_reg;
  logic [DEPTH-1:0]  v2_reg;
  logic [DATA_W-1:0] s1_reg   [DEPTH];
  logic [DATA_W-1:0] s2_reg   [DEPTH];

  logic [DEPTH-1:0]  ready;
  logic [DATA_W:0]   wake1    [DEPTH];
  logic [DATA_W:0]   wake2    [DEPTH];
  logic [DATA_W:0]   disp_cap1;
  logic [DATA_W:0]   disp_cap2;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  issue_idx;
  logic              issue_found;
  logic              disp_fire;
  logic              issue_fire;

  // CDB tag lookup: returns {hit, data}; the lowest-numbered matching port wins.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        valid,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] datas
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (valid[k] && tags[k*TAG_W +: TAG_W] == tag)
        r = {1'b1, datas[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign ready[gi] = busy_reg[gi] & v1_reg[gi] & v2_reg[gi];
      assign wake1[gi] = cdb_lookup(s1_reg[gi][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
      assign wake2[gi] = cdb_lookup(s2_reg[gi][TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
    end
  endgenerate

  assign disp_cap1 = cdb_lookup(disp_src1[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);
  assign disp_cap2 = cdb_lookup(disp_src2[TAG_W-1:0], cdb_valid, cdb_tag, cdb_data);

  // Occupancy is the population count of busy entries.
  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++)
      count = count + CNT_W'(busy_reg[i]);
  end

  assign disp_ready = (count < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready && !flush;

  // Allocation picks the lowest-index free entry.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!busy_reg[i]) free_idx = IDX_W'(i);
  end

`ifdef RS_AGE_ORDER_EN
  // age_reg[j][i] = 1 means entry j was dispatched before entry i.
  logic [DEPTH-1:0] age_reg [DEPTH];
  logic [DEPTH-1:0] oldest;

  // An entry is a candidate when it is ready and no older entry is ready.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && age_reg[j][i]) oldest[i] = 1'b0;
    end
  end

  // Select the (unique) oldest ready entry.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (oldest[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
  end

  // New entry becomes younger than every other entry; stale rows of free
  // entries are overwritten when those entries are reallocated.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
    end else if (disp_fire) begin
      for (int j = 0; j < DEPTH; j++) begin
        age_reg[free_idx][j] <= 1'b0;
        if (IDX_W'(j) != free_idx) age_reg[j][free_idx] <= 1'b1;
      end
    end
  end
`else
  // Select the lowest-index ready entry.
  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (ready[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
  end
`endif

  assign issue_valid = issue_found && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_op    = op_reg[issue_idx];
  assign issue_dest  = dest_reg[issue_idx];
  assign issue_opr1  = s1_reg[issue_idx];
  assign issue_opr2  = s2_reg[issue_idx];

  // Entry state update: wakeup, issue release and dispatch allocation.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_reg[i] && !v1_reg[i] && wake1[i][DATA_W]) begin
          v1_reg[i] <= 1'b1;
          s1_reg[i] <= wake1[i][DATA_W-1:0];
        end
        if (busy_reg[i] && !v2_reg[i] && wake2[i][DATA_W]) begin
          v2_reg[i] <= 1'b1;
          s2_reg[i] <= wake2[i][DATA_W-1:0];
        end
      end
      if (issue_fire) busy_reg[issue_idx] <= 1'b0;
      if (disp_fire) begin
        busy_reg[free_idx] <= 1'b1;
        op_reg[free_idx]   <= disp_op;
        dest_reg[free_idx] <= disp_dest;
        v1_reg[free_idx]   <= disp_v1 | disp_cap1[DATA_W];
        v2_reg[free_idx]   <= disp_v2 | disp_cap2[DATA_W];
        s1_reg[free_idx]   <= (!disp_v1 && disp_cap1[DATA_W]) ? disp_cap1[DATA_W-1:0] : disp_src1;
        s2_reg[free_idx]   <= (!disp_v2 && disp_cap2[DATA_W]) ? disp_cap2[DATA_W-1:0] : disp_src2;
      end
    end
  end

endmodule

// File: tb/tb_rs_queue.sv
// Directed self-checking bench for rs_queue (default parameters).
module tb_rs_queue;

  localparam int DEPTH = 8;
  localparam int NUM_CDB = 2;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  localparam int OP_W = 10;

  logic clk = 1'b0;
  logic reset, flush, disp_valid, disp_ready, disp_v1, disp_v2;
  logic [OP_W-1:0] disp_op;
  logic [TAG_W-1:0] disp_dest;
  logic [DATA_W-1:0] disp_src1, disp_src2;
  logic [NUM_CDB-1:0] cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic issue_valid, issue_ready;
  logic [OP_W-1:0] issue_op;
  logic [TAG_W-1:0] issue_dest;
  logic [DATA_W-1:0] issue_opr1, issue_opr2;
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_checks = 0;
  int n_fail = 0;
  logic age_mode;

  rs_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dest(disp_dest),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_src1(disp_src1), .disp_src2(disp_src2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_opr1(issue_opr1), .issue_opr2(issue_opr2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int op, input int dest, input logic v1, input int s1,
                      input logic v2, input int s2);
    disp_valid = 1'b1;
    disp_op    = OP_W'(op);
    disp_dest  = TAG_W'(dest);
    disp_v1    = v1;
    disp_src1  = DATA_W'(s1);
    disp_v2    = v2;
    disp_src2  = DATA_W'(s2);
  endtask

  initial begin
`ifdef RS_AGE_ORDER_EN
    age_mode = 1'b1;
`else
    age_mode = 1'b0;
`endif
    reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_dest = '0;
    disp_v1 = 1'b0; disp_v2 = 1'b0; disp_src1 = '0; disp_src2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    step(); step();
    chk("reset_count", 32'(count), 0);
    chk("reset_disp_ready", 32'(disp_ready), 1);
    chk("reset_issue_valid", 32'(issue_valid), 0);
    reset = 1'b0;

    // Basic dispatch with both operands ready, issued the next cycle.
    issue_ready = 1'b1;
    disp(1, 5, 1'b1, 10, 1'b1, 20);
    step(); disp_valid = 1'b0;
    chk("basic_issue_valid", 32'(issue_valid), 1);
    chk("basic_op", 32'(issue_op), 1);
    chk("basic_dest", 32'(issue_dest), 5);
    chk("basic_opr1", issue_opr1, 10);
    chk("basic_opr2", issue_opr2, 20);
    chk("basic_count1", 32'(count), 1);
    step();
    chk("basic_count0", 32'(count), 0);
    chk("basic_idle", 32'(issue_valid), 0);

    // Fill all entries waiting on tag 3, then wake them with one broadcast.
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(2, i, 1'b0, 3, 1'b1, 100 + i);
      step();
    end
    disp_valid = 1'b0;
    chk("full_count", 32'(count), 8);
    chk("full_disp_ready", 32'(disp_ready), 0);
    chk("full_issue_valid", 32'(issue_valid), 0);
    disp(9, 32, 1'b1, 1, 1'b1, 1);
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd3}; cdb_data = {32'h0, 32'h55};
    step();
    disp_valid = 1'b0; cdb_valid = '0;
    chk("full_reject_count", 32'(count), 8);
    issue_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(issue_valid), 1);
      chk($sformatf("drain%0d_dest", i), 32'(issue_dest), 32'(i));
      chk($sformatf("drain%0d_opr1", i), issue_opr1, 32'h55);
      chk($sformatf("drain%0d_opr2", i), issue_opr2, 32'(100 + i));
      step();
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_idle", 32'(issue_valid), 0);

    // Same-cycle CDB capture at dispatch on port 1.
    disp(3, 9, 1'b0, 7, 1'b1, 1);
    cdb_valid = 2'b10; cdb_tag = {6'd7, 6'd1}; cdb_data = {32'h99, 32'h12};
    step();
    disp_valid = 1'b0; cdb_valid = '0;
    chk("cap_issue_valid", 32'(issue_valid), 1);
    chk("cap_dest", 32'(issue_dest), 9);
    chk("cap_opr1", issue_opr1, 32'h99);
    step();
    chk("cap_count", 32'(count), 0);

    // Two CDB ports match the same tag: port 0 wins.
    issue_ready = 1'b0;
    disp(4, 10, 1'b0, 4, 1'b1, 2);
    step(); disp_valid = 1'b0;
    chk("prio_waiting", 32'(issue_valid), 0);
    chk("prio_count", 32'(count), 1);
    cdb_valid = 2'b11; cdb_tag = {6'd4, 6'd4}; cdb_data = {32'h22, 32'h11};
    step(); cdb_valid = '0;
    chk("prio_ready", 32'(issue_valid), 1);
    chk("prio_opr1", issue_opr1, 32'h11);
    step();
    chk("prio_hold_count", 32'(count), 1);
    issue_ready = 1'b1;
    step();
    chk("prio_done_count", 32'(count), 0);

    // Age ordering: A into entry 2, B into entry 0, both ready together.
    issue_ready = 1'b0;
    disp(5, 20, 1'b1, 1, 1'b1, 1); step();
    disp(5, 21, 1'b1, 2, 1'b1, 2); step();
    disp(5, 22, 1'b0, 12, 1'b1, 3); step();
    disp_valid = 1'b0;
    chk("age_count3", 32'(count), 3);
    issue_ready = 1'b1;
    chk("age_pre0_dest", 32'(issue_dest), 20);
    step();
    chk("age_pre1_dest", 32'(issue_dest), 21);
    step();
    issue_ready = 1'b0;
    chk("age_count1", 32'(count), 1);
    chk("age_a_waiting", 32'(issue_valid), 0);
    disp(5, 23, 1'b1, 4, 1'b1, 5);
    step(); disp_valid = 1'b0;
    chk("age_b_only", 32'(issue_dest), 23);
    cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd12}; cdb_data = {32'h0, 32'hAA};
    step(); cdb_valid = '0;
    chk("age_first_dest", 32'(issue_dest), age_mode ? 22 : 23);
    chk("age_first_opr1", issue_opr1, age_mode ? 32'hAA : 32'h4);
    issue_ready = 1'b1;
    step();
    chk("age_second_dest", 32'(issue_dest), age_mode ? 23 : 22);
    step();
    chk("age_done_count", 32'(count), 0);

    // Flush with a simultaneous dispatch: everything discarded.
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(6, 30 + i, 1'b1, i, 1'b1, i);
      step();
    end
    disp_valid = 1'b0;
    chk("flush_pre_count", 32'(count), 4);
    flush = 1'b1;
    disp(6, 63, 1'b1, 0, 1'b1, 0);
    #1;
    chk("flush_cycle_issue", 32'(issue_valid), 0);
    step();
    flush = 1'b0; disp_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_issue_valid", 32'(issue_valid), 0);
    chk("flush_disp_ready", 32'(disp_ready), 1);
    issue_ready = 1'b1;
    step();
    chk("flush_dropped", 32'(issue_valid), 0);

    // Dispatch and issue in the same cycle keep the count unchanged.
    issue_ready = 1'b0;
    disp(7, 40, 1'b1, 1, 1'b1, 1);
    step();
    chk("simul_count1", 32'(count), 1);
    issue_ready = 1'b1;
    disp(7, 41, 1'b1, 2, 1'b1, 2);
    chk("simul_issue_dest", 32'(issue_dest), 40);
    step(); disp_valid = 1'b0;
    chk("simul_count_hold", 32'(count), 1);
    chk("simul_next_dest", 32'(issue_dest), 41);
    step();
    chk("simul_count0", 32'(count), 0);

    // Reset mid-operation overrides dispatch and issue.
    issue_ready = 1'b0;
    disp(8, 50, 1'b1, 1, 1'b1, 1); step();
    disp(8, 51, 1'b0, 2, 1'b1, 1); step();
    chk("mid_pre_count", 32'(count), 2);
    reset = 1'b1; issue_ready = 1'b1;
    disp(8, 52, 1'b1, 3, 1'b1, 3);
    step();
    reset = 1'b0; disp_valid = 1'b0;
    chk("mid_reset_count", 32'(count), 0);
    chk("mid_reset_issue", 32'(issue_valid), 0);
    chk("mid_reset_ready", 32'(disp_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
